// File: rtl/snake_display_pkg.sv
// Shared constants and types for the LED matrix display path.
// Rows are indexed 0..7, where row 0 is the frame's row_1.
package snake_display_pkg;

   localparam int unsigned NUM_ROWS = 8;
   localparam int unsigned NUM_COLS = 8;

   typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} scan_state_e;

   typedef logic [2:0] row_idx_t;

   function automatic logic [NUM_ROWS-1:0] row_onehot(input row_idx_t idx);
      logic [NUM_ROWS-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/scan_dwell_timer.sv
// Loadable down-counter shared by the blank and drive phases of the scanner.
// Loading N-1 makes expire_o pulse on the Nth cycle after the load.
module scan_dwell_timer #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_value_i,
   input  logic             clear_i,
   output logic             expire_o
);

   logic [WIDTH-1:0] count_q, count_d;
   logic             active_q, active_d;

   always_comb begin
      count_d  = count_q;
      active_d = active_q;
      if (clear_i) begin
         count_d  = '0;
         active_d = 1'b0;
      end else if (load_i) begin
         count_d  = load_value_i;
         active_d = 1'b1;
      end else if (active_q) begin
         // Stop at zero so an unreloaded timer expires exactly once.
         if (count_q == '0) begin
            active_d = 1'b0;
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q  <= '0;
         active_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         active_q <= active_d;
      end
   end

   assign expire_o = active_q && (count_q == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// Row-multiplexed 8x8 LED matrix driver with a frame-boundary shadow buffer
// so the matrix only ever shows complete frames.
module led_matrix_scanner
   import snake_display_pkg::*;
#(
   parameter int unsigned CLK_DIV        = 1000,
   parameter int unsigned BLANK_CYCLES   = 2,
   parameter int unsigned COL_ACTIVE_LOW = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] row_1,
   input  logic [7:0] row_2,
   input  logic [7:0] row_3,
   input  logic [7:0] row_4,
   input  logic [7:0] row_5,
   input  logic [7:0] row_6,
   input  logic [7:0] row_7,
   input  logic [7:0] row_8,
   input  logic       load_req,
   output logic       load_ack,
   output logic [7:0] row_sel,
   output logic [7:0] col_out,
   output logic       frame_done
);

   localparam int unsigned MAX_CYCLES = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES) + 1;
   localparam logic [TIMER_W-1:0] DRIVE_LOAD = TIMER_W'(CLK_DIV - 1);
   localparam logic [TIMER_W-1:0] BLANK_LOAD =
      TIMER_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [NUM_COLS-1:0] COL_MASK = (COL_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NUM_COLS-1:0] COL_OFF  = COL_MASK;

   typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] frame_t;

   scan_state_e         state_q, state_d;
   row_idx_t            row_idx_q, row_idx_d;
   frame_t              shadow_q, shadow_d;
   frame_t              frame_in;
   logic                pending_q, pending_d;
   logic                load_ack_d, frame_done_d;
   logic [NUM_ROWS-1:0] row_sel_d;
   logic [NUM_COLS-1:0] col_out_d;

   logic                tmr_load, tmr_clear, tmr_expire;
   logic [TIMER_W-1:0]  tmr_value;
   logic                start_row, boundary, capture, new_req;

   assign frame_in = {row_8, row_7, row_6, row_5, row_4, row_3, row_2, row_1};

   scan_dwell_timer #(
      .WIDTH (TIMER_W)
   ) u_dwell (
      .clk_i        (clk),
      .rst_i        (rst),
      .load_i       (tmr_load),
      .load_value_i (tmr_value),
      .clear_i      (tmr_clear),
      .expire_o     (tmr_expire)
   );

   always_comb begin
      state_d      = state_q;
      row_idx_d    = row_idx_q;
      shadow_d     = shadow_q;
      pending_d    = pending_q;
      frame_done_d = 1'b0;
      tmr_load     = 1'b0;
      tmr_clear    = 1'b0;
      tmr_value    = DRIVE_LOAD;
      start_row    = 1'b0;
      boundary     = 1'b0;
      // A request still high during its own ack cycle is the old request.
      new_req      = load_req && !load_ack;

      if (!enable) begin
         state_d   = S_IDLE;
         row_idx_d = '0;
         tmr_clear = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               boundary  = 1'b1;
               row_idx_d = '0;
               start_row = 1'b1;
            end
            S_BLANK: begin
               if (tmr_expire) begin
                  state_d   = S_DRIVE;
                  tmr_load  = 1'b1;
                  tmr_value = DRIVE_LOAD;
               end
            end
            S_DRIVE: begin
               if (tmr_expire) begin
                  start_row = 1'b1;
                  if (row_idx_q == row_idx_t'(NUM_ROWS - 1)) begin
                     row_idx_d    = '0;
                     frame_done_d = 1'b1;
                     boundary     = 1'b1;
                  end else begin
                     row_idx_d = row_idx_q + 3'd1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase

         if (start_row) begin
            tmr_load = 1'b1;
            if (BLANK_CYCLES == 0) begin
               state_d   = S_DRIVE;
               tmr_value = DRIVE_LOAD;
            end else begin
               state_d   = S_BLANK;
               tmr_value = BLANK_LOAD;
            end
         end
      end

      capture = boundary && (pending_q || new_req);
      if (capture) begin
         shadow_d  = frame_in;
         pending_d = 1'b0;
      end else if (new_req) begin
         pending_d = 1'b1;
      end
      load_ack_d = capture;

      // Outputs are computed from next state so they register alongside it.
      if (state_d == S_DRIVE) begin
         row_sel_d = row_onehot(row_idx_d);
         col_out_d = shadow_d[row_idx_d] ^ COL_MASK;
      end else begin
         row_sel_d = '0;
         col_out_d = COL_OFF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         row_idx_q  <= '0;
         shadow_q   <= '0;
         pending_q  <= 1'b0;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
         row_sel    <= '0;
         col_out    <= COL_OFF;
      end else begin
         state_q    <= state_d;
         row_idx_q  <= row_idx_d;
         shadow_q   <= shadow_d;
         pending_q  <= pending_d;
         load_ack   <= load_ack_d;
         frame_done <= frame_done_d;
         row_sel    <= row_sel_d;
         col_out    <= col_out_d;
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench for led_matrix_scanner: two parameterisations driven in parallel,
// expected outputs derived from elapsed scan time and frame arithmetic.
module tb_led_matrix_scanner;

   localparam int NDUT = 2;
   typedef logic [17:0] obs_t;  // {row_sel, col_out, load_ack, frame_done}

   int cd [NDUT] = '{4, 1};
   int bl [NDUT] = '{1, 0};
   int al [NDUT] = '{0, 1};

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       load_req;
   logic [7:0] row_in [8];

   logic       ack_a, done_a, ack_b, done_b;
   logic [7:0] rsel_a, col_a, rsel_b, col_b;

   always #5 clk = ~clk;

   led_matrix_scanner #(
      .CLK_DIV        (4),
      .BLANK_CYCLES   (1),
      .COL_ACTIVE_LOW (0)
   ) dut_a (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .row_1      (row_in[0]),
      .row_2      (row_in[1]),
      .row_3      (row_in[2]),
      .row_4      (row_in[3]),
      .row_5      (row_in[4]),
      .row_6      (row_in[5]),
      .row_7      (row_in[6]),
      .row_8      (row_in[7]),
      .load_req   (load_req),
      .load_ack   (ack_a),
      .row_sel    (rsel_a),
      .col_out    (col_a),
      .frame_done (done_a)
   );

   led_matrix_scanner #(
      .CLK_DIV        (1),
      .BLANK_CYCLES   (0),
      .COL_ACTIVE_LOW (1)
   ) dut_b (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .row_1      (row_in[0]),
      .row_2      (row_in[1]),
      .row_3      (row_in[2]),
      .row_4      (row_in[3]),
      .row_5      (row_in[4]),
      .row_6      (row_in[5]),
      .row_7      (row_in[6]),
      .row_8      (row_in[7]),
      .load_req   (load_req),
      .load_ack   (ack_b),
      .row_sel    (rsel_b),
      .col_out    (col_b),
      .frame_done (done_b)
   );

   // Reference model state: cycles since scan start (-1 = idle), displayed frame,
   // outstanding request flag, and last ack output.
   int         t_m       [NDUT];
   logic [7:0] shadow_m  [NDUT][8];
   bit         pending_m [NDUT];
   bit         ack_m     [NDUT];

   obs_t exp_a [$];
   obs_t exp_b [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void model_reset();
      for (int k = 0; k < NDUT; k++) begin
         t_m[k]       = -1;
         pending_m[k] = 1'b0;
         ack_m[k]     = 1'b0;
         for (int r = 0; r < 8; r++) shadow_m[k][r] = 8'h00;
      end
   endfunction

   function automatic logic [7:0] off_val(int k);
      return (al[k] != 0) ? 8'hFF : 8'h00;
   endfunction

   // Expected output for the cycle following a clock edge with current inputs.
   function automatic obs_t model_step(int k);
      int         period, slot_len, p, slot, r, t_new;
      bit         req, boundary, cap, fd;
      logic [7:0] rs, co;
      req = load_req && !ack_m[k];
      if (!enable) begin
         t_m[k]   = -1;
         ack_m[k] = 1'b0;
         if (req) pending_m[k] = 1'b1;
         return {8'h00, off_val(k), 1'b0, 1'b0};
      end
      slot_len = bl[k] + cd[k];
      period   = 8 * slot_len;
      t_new    = (t_m[k] < 0) ? 0 : t_m[k] + 1;
      p        = t_new % period;
      boundary = (p == 0);
      fd       = boundary && (t_m[k] >= 0);
      t_m[k]   = t_new;
      cap      = boundary && (pending_m[k] || req);
      if (cap) begin
         for (int i = 0; i < 8; i++) shadow_m[k][i] = row_in[i];
         pending_m[k] = 1'b0;
      end else if (req) begin
         pending_m[k] = 1'b1;
      end
      ack_m[k] = cap;
      r    = p / slot_len;
      slot = p % slot_len;
      if (slot < bl[k]) begin
         rs = 8'h00;
         co = off_val(k);
      end else begin
         rs = 8'(1 << r);
         co = shadow_m[k][r] ^ off_val(k);
      end
      return {rs, co, cap, fd};
   endfunction

   task automatic compare(input string name, input obs_t got, input obs_t want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s @%0t: got row_sel=%h col_out=%h ack=%b done=%b, want row_sel=%h col_out=%h ack=%b done=%b",
                  name, $time, got[17:10], got[9:2], got[1], got[0],
                  want[17:10], want[9:2], want[1], want[0]);
      end
   endtask

   task automatic check_off(input string name);
      compare({name, "_a"}, {rsel_a, col_a, ack_a, done_a}, {8'h00, 8'h00, 1'b0, 1'b0});
      compare({name, "_b"}, {rsel_b, col_b, ack_b, done_b}, {8'h00, 8'hFF, 1'b0, 1'b0});
   endtask

   task automatic step();
      @(posedge clk);
      exp_a.push_back(model_step(0));
      exp_b.push_back(model_step(1));
      #2;
   endtask

   // Advance until the next clock edge lands on phase p of dut_a's 40-cycle frame.
   task automatic step_to_phase(input int p);
      for (int i = 0; i < 80; i++) begin
         if (t_m[0] >= 0 && ((t_m[0] + 1) % 40) == p) break;
         step();
      end
   endtask

   task automatic async_reset(input int hold);
      #1;
      rst = 1'b1;
      exp_a.delete();
      exp_b.delete();
      model_reset();
      #1;
      check_off("reset_now");
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_off("reset_held");
      end
      @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   initial begin : monitor
      obs_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (exp_a.size() > 0) begin
               e = exp_a.pop_front();
               compare("scan_a", {rsel_a, col_a, ack_a, done_a}, e);
            end
            if (exp_b.size() > 0) begin
               e = exp_b.pop_front();
               compare("scan_b", {rsel_b, col_b, ack_b, done_b}, e);
            end
         end
      end
   end

   initial begin : stimulus
      int hold_cnt;
      hold_cnt = 0;
      rst      = 1'b1;
      enable   = 1'b0;
      load_req = 1'b0;
      for (int i = 0; i < 8; i++) row_in[i] = 8'h00;
      model_reset();
      #1;
      check_off("reset_init");
      repeat (3) @(negedge clk);
      check_off("reset_init_held");
      @(posedge clk);
      #3;
      rst = 1'b0;

      // Basic scan: row_1 = 81 loaded as enable rises.
      step();
      row_in[0] = 8'h81;
      load_req  = 1'b1;
      enable    = 1'b1;
      step();
      load_req = 1'b0;
      repeat (90) step();

      // Tear-free update requested during row 5.
      step_to_phase(22);
      row_in[2] = 8'hFF;
      load_req  = 1'b1;
      step();
      load_req = 1'b0;
      repeat (90) step();

      // Enable drop in the middle of row 4, then restart.
      step_to_phase(17);
      enable = 1'b0;
      repeat (4) step();
      enable = 1'b1;
      repeat (60) step();

      // Randomised traffic, with an asynchronous reset partway through.
      for (int phase = 0; phase < 2; phase++) begin
         for (int n = 0; n < 1200; n++) begin
            if (enable) begin
               if ($urandom_range(0, 79) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               enable = 1'b1;
            end
            if (hold_cnt > 0) begin
               hold_cnt--;
               if (hold_cnt == 0) load_req = 1'b0;
            end else if ($urandom_range(0, 24) == 0) begin
               for (int i = 0; i < 8; i++) row_in[i] = 8'($urandom);
               load_req = 1'b1;
               hold_cnt = $urandom_range(1, 3);
            end
            step();
         end
         if (phase == 0) begin
            step_to_phase(13);
            step();
            async_reset(3);
            load_req = 1'b0;
            hold_cnt = 0;
         end
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
